// File: rtl/lsb_mc.sv
// In-order load-store buffer: circular queue of memory ops with CDB wakeup,
// one outstanding memory access, MMIO/store ordering against the ROB head.
module lsb_mc #(
  parameter int          DEPTH   = 8,
  parameter int          ROB_W   = 3,
  parameter int          CDB_N   = 2,
  parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   rdy_in,
  input  logic                   rob_clear,
  input  logic                   rob_empty,
  input  logic [ROB_W-1:0]       rob_head_id,
  input  logic                   dc_valid,
  input  logic [10:0]            dc_op,
  input  logic [31:0]            dc_imm,
  input  logic                   dc_iQi,
  input  logic                   dc_iQj,
  input  logic [ROB_W-1:0]       dc_Qi,
  input  logic [ROB_W-1:0]       dc_Qj,
  input  logic [31:0]            dc_Vi,
  input  logic [31:0]            dc_Vj,
  input  logic [ROB_W-1:0]       dc_Qdest,
  output logic                   lsb_full,
  input  logic [CDB_N-1:0]       cdb_valid,
  input  logic [CDB_N*ROB_W-1:0] cdb_rob_id,
  input  logic [CDB_N*32-1:0]    cdb_data,
  output logic                   mem_req,
  output logic                   mem_is_store,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_data,
  output logic [2:0]             mem_op,
  input  logic                   mem_stuck,
  input  logic                   mem_done,
  input  logic [31:0]            mem_rdata,
  output logic                   lsb_has_output,
  output logic [ROB_W-1:0]       lsb_rob_id,
  output logic [31:0]            lsb_output
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    head_q, tail_q;
  logic [PW:0]      count_q;
  logic             mem_req_q, mem_is_store_q, has_out_q;
  logic [31:0]      mem_addr_q, mem_data_q, out_q;
  logic [2:0]       mem_op_q;
  logic [ROB_W-1:0] rob_id_q;

  // ins[30] distinguishes nothing for memory ops; kept on the port only
  logic unused_ins30;
  assign unused_ins30 = dc_op[10];

  logic [9:0]       op_q   [DEPTH];
  logic [31:0]      imm_q  [DEPTH];
  logic [31:0]      v1_q   [DEPTH];
  logic [31:0]      v2_q   [DEPTH];
  logic [ROB_W-1:0] q1_q   [DEPTH];
  logic [ROB_W-1:0] q2_q   [DEPTH];
  logic [ROB_W-1:0] qdes_q [DEPTH];
  logic [DEPTH-1:0] iq1_q, iq2_q;

  logic        in_iq1, in_iq2;
  logic [31:0] in_v1, in_v2;

  // Descending scan so the lowest-index matching channel is the final writer
  always_comb begin
    in_iq1 = dc_iQi;
    in_v1  = dc_Vi;
    in_iq2 = dc_iQj;
    in_v2  = dc_Vj;
    for (int k = CDB_N-1; k >= 0; k--) begin
      if (!dc_iQi && cdb_valid[k] && cdb_rob_id[k*ROB_W +: ROB_W] == dc_Qi) begin
        in_iq1 = 1'b1;
        in_v1  = cdb_data[k*32 +: 32];
      end
      if (!dc_iQj && cdb_valid[k] && cdb_rob_id[k*ROB_W +: ROB_W] == dc_Qj) begin
        in_iq2 = 1'b1;
        in_v2  = cdb_data[k*32 +: 32];
      end
    end
  end

  logic        hd_store, hd_ordered, can_issue;
  logic [31:0] hd_addr;
  assign hd_store   = (op_q[head_q][6:0] == 7'b0100011);
  assign hd_addr    = v1_q[head_q] + imm_q[head_q];
  assign hd_ordered = !rob_empty && (rob_head_id == qdes_q[head_q]);
  assign can_issue  = (count_q != '0) && iq1_q[head_q] && iq2_q[head_q] && !mem_stuck &&
                      ((!hd_store && hd_addr < IO_BASE) || hd_ordered);

  logic issue, free, flush, emit, insert;
  assign insert = rdy_in && dc_valid && !rob_clear && (state_q != S_DRAIN);

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    free    = 1'b0;
    flush   = 1'b0;
    emit    = 1'b0;
    if (rdy_in) begin
      case (state_q)
        S_IDLE: begin
          if (rob_clear) flush = 1'b1;
          else if (can_issue) begin
            issue   = 1'b1;
            state_d = S_BUSY;
          end
        end
        S_BUSY: begin
          if (rob_clear) begin
            flush   = 1'b1;
            state_d = mem_done ? S_IDLE : S_DRAIN;
          end else if (mem_done) begin
            free    = 1'b1;
            emit    = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_DRAIN: begin
          flush = rob_clear;
          if (mem_done) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q        <= S_IDLE;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      mem_req_q      <= 1'b0;
      mem_is_store_q <= 1'b0;
      mem_addr_q     <= '0;
      mem_data_q     <= '0;
      mem_op_q       <= '0;
      has_out_q      <= 1'b0;
      rob_id_q       <= '0;
      out_q          <= '0;
    end else if (rdy_in) begin
      state_q <= state_d;
      if (flush) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (insert) tail_q <= tail_q + PW'(1);
        if (free)   head_q <= head_q + PW'(1);
        count_q <= count_q + (PW+1)'(insert) - (PW+1)'(free);
      end
      if (issue) begin
        mem_req_q      <= 1'b1;
        mem_is_store_q <= hd_store;
        mem_addr_q     <= hd_addr;
        mem_data_q     <= v2_q[head_q];
        mem_op_q       <= op_q[head_q][9:7];
      end else if (state_q != S_IDLE && mem_done) begin
        mem_req_q <= 1'b0;
      end
      has_out_q <= emit;
      if (emit) begin
        rob_id_q <= qdes_q[head_q];
        out_q    <= hd_store ? 32'd0 : mem_rdata;
      end
    end else begin
      has_out_q <= 1'b0;
    end
  end

  // Entry payload needs no reset: occupancy is tracked by head/count alone
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      for (int e = 0; e < DEPTH; e++) begin
        for (int k = CDB_N-1; k >= 0; k--) begin
          if (!iq1_q[e] && cdb_valid[k] && cdb_rob_id[k*ROB_W +: ROB_W] == q1_q[e]) begin
            iq1_q[e] <= 1'b1;
            v1_q[e]  <= cdb_data[k*32 +: 32];
          end
          if (!iq2_q[e] && cdb_valid[k] && cdb_rob_id[k*ROB_W +: ROB_W] == q2_q[e]) begin
            iq2_q[e] <= 1'b1;
            v2_q[e]  <= cdb_data[k*32 +: 32];
          end
        end
      end
      if (insert) begin
        op_q[tail_q]   <= dc_op[9:0];
        imm_q[tail_q]  <= dc_imm;
        iq1_q[tail_q]  <= in_iq1;
        q1_q[tail_q]   <= dc_Qi;
        v1_q[tail_q]   <= in_v1;
        iq2_q[tail_q]  <= in_iq2;
        q2_q[tail_q]   <= dc_Qj;
        v2_q[tail_q]   <= in_v2;
        qdes_q[tail_q] <= dc_Qdest;
      end
    end
  end

  assign lsb_full       = (count_q >= (PW+1)'(DEPTH-1)) || (state_q == S_DRAIN);
  assign mem_req        = mem_req_q;
  assign mem_is_store   = mem_is_store_q;
  assign mem_addr       = mem_addr_q;
  assign mem_data       = mem_data_q;
  assign mem_op         = mem_op_q;
  assign lsb_has_output = has_out_q;
  assign lsb_rob_id     = rob_id_q;
  assign lsb_output     = out_q;
endmodule

// File: tb/tb_lsb_mc.sv
// Directed bench for lsb_mc: issue, wakeup, ordering, full/wrap, stall,
// flush draining and asynchronous reset.
module tb_lsb_mc;
  localparam int DEPTH = 8;
  localparam int ROB_W = 3;
  localparam int CDB_N = 2;
  localparam logic [10:0] LD = {1'b0, 3'b010, 7'b0000011};
  localparam logic [10:0] ST = {1'b0, 3'b010, 7'b0100011};

  logic clk_in = 1'b0, rst_n_in, rdy_in, rob_clear, rob_empty;
  logic [ROB_W-1:0] rob_head_id, dc_Qi, dc_Qj, dc_Qdest, lsb_rob_id;
  logic dc_valid, dc_iQi, dc_iQj, lsb_full, mem_req, mem_is_store, mem_stuck, mem_done, lsb_has_output;
  logic [10:0] dc_op;
  logic [31:0] dc_imm, dc_Vi, dc_Vj, mem_addr, mem_data, mem_rdata, lsb_output;
  logic [CDB_N-1:0] cdb_valid;
  logic [CDB_N*ROB_W-1:0] cdb_rob_id;
  logic [CDB_N*32-1:0] cdb_data;
  logic [2:0] mem_op;
  int tests = 0, fails = 0;

  always #5 clk_in = ~clk_in;

  lsb_mc #(.DEPTH(DEPTH), .ROB_W(ROB_W), .CDB_N(CDB_N), .IO_BASE(32'h0003_0000)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
    .rob_empty(rob_empty), .rob_head_id(rob_head_id), .dc_valid(dc_valid), .dc_op(dc_op),
    .dc_imm(dc_imm), .dc_iQi(dc_iQi), .dc_iQj(dc_iQj), .dc_Qi(dc_Qi), .dc_Qj(dc_Qj),
    .dc_Vi(dc_Vi), .dc_Vj(dc_Vj), .dc_Qdest(dc_Qdest), .lsb_full(lsb_full),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_data(cdb_data),
    .mem_req(mem_req), .mem_is_store(mem_is_store), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_op(mem_op), .mem_stuck(mem_stuck), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .lsb_has_output(lsb_has_output), .lsb_rob_id(lsb_rob_id), .lsb_output(lsb_output));

  // Decoder must never insert into a completely full queue
  always @(posedge clk_in) begin
    if (rst_n_in && rdy_in && dc_valid && dut.count_q == 4'd8) begin
      fails++;
      $display("FAIL insert_when_full count=8");
    end
  end

  task automatic cyc;
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive_ins(input logic [10:0] op, input logic [31:0] vi, input logic [31:0] imm,
                           input logic iqj, input logic [2:0] qj, input logic [31:0] vj,
                           input logic [2:0] qd);
    dc_valid = 1'b1; dc_op = op; dc_Vi = vi; dc_imm = imm; dc_iQi = 1'b1; dc_Qi = '0;
    dc_iQj = iqj; dc_Qj = qj; dc_Vj = vj; dc_Qdest = qd;
  endtask

  task automatic test_reset;
    rst_n_in = 1'b0;
    cyc(); cyc();
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req got=%0b exp=0", mem_req); end
    tests++; if (lsb_has_output !== 1'b0) begin fails++; $display("FAIL reset_has_output got=%0b exp=0", lsb_has_output); end
    tests++; if (lsb_full !== 1'b0) begin fails++; $display("FAIL reset_full got=%0b exp=0", lsb_full); end
    tests++; if (mem_addr !== 32'd0) begin fails++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    rst_n_in = 1'b1;
    cyc();
  endtask

  task automatic test_basic_load;
    drive_ins(LD, 32'h100, 32'd4, 1'b1, 3'd0, 32'd0, 3'd3);
    cyc(); dc_valid = 1'b0;
    cyc();
    tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL load_req got=%0b exp=1", mem_req); end
    tests++; if (mem_addr !== 32'h104) begin fails++; $display("FAIL load_addr got=%h exp=104", mem_addr); end
    tests++; if (mem_is_store !== 1'b0 || mem_op !== 3'b010) begin fails++; $display("FAIL load_kind st=%0b op=%0d exp 0/2", mem_is_store, mem_op); end
    mem_done = 1'b1; mem_rdata = 32'hDEADBEEF;
    cyc(); mem_done = 1'b0;
    tests++; if (lsb_has_output !== 1'b1) begin fails++; $display("FAIL load_out_valid got=%0b exp=1", lsb_has_output); end
    tests++; if (lsb_rob_id !== 3'd3) begin fails++; $display("FAIL load_rob_id got=%0d exp=3", lsb_rob_id); end
    tests++; if (lsb_output !== 32'hDEADBEEF) begin fails++; $display("FAIL load_data got=%h exp=deadbeef", lsb_output); end
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL load_req_drop got=%0b exp=0", mem_req); end
    cyc();
    tests++; if (lsb_has_output !== 1'b0) begin fails++; $display("FAIL load_out_pulse got=%0b exp=0", lsb_has_output); end
  endtask

  task automatic test_cdb_wakeup;
    drive_ins(ST, 32'h200, 32'd8, 1'b0, 3'd5, 32'd0, 3'd6);
    cyc(); dc_valid = 1'b0;
    cdb_valid = 2'b11; cdb_rob_id = {3'd5, 3'd4}; cdb_data = {32'h55, 32'h44};
    cyc(); cdb_valid = 2'b00;
    cyc(); cyc();
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL store_hold got=%0b exp=0", mem_req); end
    rob_empty = 1'b0; rob_head_id = 3'd6;
    cyc();
    tests++; if (mem_req !== 1'b1 || mem_is_store !== 1'b1) begin fails++; $display("FAIL store_issue req=%0b st=%0b exp 1/1", mem_req, mem_is_store); end
    tests++; if (mem_data !== 32'h55) begin fails++; $display("FAIL store_data got=%h exp=55", mem_data); end
    tests++; if (mem_addr !== 32'h208) begin fails++; $display("FAIL store_addr got=%h exp=208", mem_addr); end
    mem_done = 1'b1; mem_rdata = 32'h1234;
    cyc(); mem_done = 1'b0; rob_empty = 1'b1;
    tests++; if (lsb_has_output !== 1'b1 || lsb_output !== 32'd0 || lsb_rob_id !== 3'd6) begin
      fails++; $display("FAIL store_out v=%0b d=%h id=%0d exp 1/0/6", lsb_has_output, lsb_output, lsb_rob_id); end
    cyc();
  endtask

  task automatic test_insert_bypass;
    rob_empty = 1'b0; rob_head_id = 3'd1;
    drive_ins(ST, 32'h300, 32'd0, 1'b0, 3'd2, 32'd0, 3'd1);
    cdb_valid = 2'b11; cdb_rob_id = {3'd2, 3'd2}; cdb_data = {32'hB1, 32'hA0};
    cyc(); dc_valid = 1'b0; cdb_valid = 2'b00;
    cyc();
    tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL bypass_issue got=%0b exp=1", mem_req); end
    tests++; if (mem_data !== 32'hA0) begin fails++; $display("FAIL bypass_prio got=%h exp=a0", mem_data); end
    mem_done = 1'b1; mem_rdata = 32'd0;
    cyc(); mem_done = 1'b0; rob_empty = 1'b1;
    cyc();
  endtask

  task automatic test_mmio;
    drive_ins(LD, 32'h30000, 32'd0, 1'b1, 3'd0, 32'd0, 3'd2);
    cyc(); dc_valid = 1'b0;
    cyc(); cyc(); cyc();
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL mmio_hold got=%0b exp=0", mem_req); end
    rob_empty = 1'b0; rob_head_id = 3'd2;
    cyc();
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h30000) begin fails++; $display("FAIL mmio_issue req=%0b addr=%h exp 1/30000", mem_req, mem_addr); end
    mem_done = 1'b1; mem_rdata = 32'h9;
    cyc(); mem_done = 1'b0; rob_empty = 1'b1;
    drive_ins(LD, 32'h2FFF0, 32'hC, 1'b1, 3'd0, 32'd0, 3'd5);
    cyc(); dc_valid = 1'b0;
    cyc();
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h2FFFC) begin fails++; $display("FAIL below_io_issue req=%0b addr=%h exp 1/2fffc", mem_req, mem_addr); end
    mem_done = 1'b1;
    cyc(); mem_done = 1'b0;
    cyc();
  endtask

  task automatic test_rdy_stall;
    drive_ins(LD, 32'h500, 32'd0, 1'b1, 3'd0, 32'd0, 3'd4);
    cyc(); dc_valid = 1'b0;
    cyc();
    rdy_in = 1'b0;
    cyc(); cyc();
    tests++; if (mem_req !== 1'b1 || lsb_has_output !== 1'b0) begin fails++; $display("FAIL stall_hold req=%0b out=%0b exp 1/0", mem_req, lsb_has_output); end
    rdy_in = 1'b1; mem_done = 1'b1; mem_rdata = 32'h77;
    cyc(); mem_done = 1'b0;
    tests++; if (lsb_has_output !== 1'b1 || lsb_output !== 32'h77 || lsb_rob_id !== 3'd4) begin
      fails++; $display("FAIL stall_resume v=%0b d=%h id=%0d exp 1/77/4", lsb_has_output, lsb_output, lsb_rob_id); end
    cyc();
  endtask

  task automatic test_full_wrap;
    mem_stuck = 1'b1;
    for (int i = 0; i < DEPTH-1; i++) begin
      drive_ins(LD, 32'h1000 + 32'(i*16), 32'd0, 1'b1, 3'd0, 32'd0, 3'(i));
      cyc();
      if (i == DEPTH-3) begin
        tests++; if (lsb_full !== 1'b0) begin fails++; $display("FAIL full_early got=%0b exp=0", lsb_full); end
      end
    end
    dc_valid = 1'b0;
    tests++; if (lsb_full !== 1'b1) begin fails++; $display("FAIL full_set got=%0b exp=1", lsb_full); end
    mem_stuck = 1'b0;
    cyc();
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h1000) begin fails++; $display("FAIL full_issue0 req=%0b addr=%h exp 1/1000", mem_req, mem_addr); end
    mem_done = 1'b1; mem_rdata = 32'hA000;
    drive_ins(LD, 32'h1070, 32'd0, 1'b1, 3'd0, 32'd0, 3'd7);
    cyc(); mem_done = 1'b0; dc_valid = 1'b0;
    tests++; if (lsb_has_output !== 1'b1 || lsb_rob_id !== 3'd0) begin fails++; $display("FAIL full_done0 v=%0b id=%0d exp 1/0", lsb_has_output, lsb_rob_id); end
    tests++; if (lsb_full !== 1'b1) begin fails++; $display("FAIL full_swap got=%0b exp=1", lsb_full); end
    for (int i = 1; i < DEPTH; i++) begin
      cyc();
      tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h1000 + 32'(i*16)) begin
        fails++; $display("FAIL wrap_issue%0d req=%0b addr=%h exp 1/%h", i, mem_req, mem_addr, 32'h1000 + 32'(i*16)); end
      mem_done = 1'b1; mem_rdata = 32'hA000 + 32'(i);
      cyc(); mem_done = 1'b0;
      tests++; if (lsb_has_output !== 1'b1 || lsb_rob_id !== 3'(i) || lsb_output !== 32'hA000 + 32'(i)) begin
        fails++; $display("FAIL wrap_done%0d v=%0b id=%0d d=%h", i, lsb_has_output, lsb_rob_id, lsb_output); end
    end
    cyc();
    tests++; if (lsb_full !== 1'b0 || mem_req !== 1'b0) begin fails++; $display("FAIL wrap_empty full=%0b req=%0b exp 0/0", lsb_full, mem_req); end
  endtask

  task automatic test_flush_busy;
    drive_ins(LD, 32'h40, 32'd0, 1'b1, 3'd0, 32'd0, 3'd1);
    cyc(); dc_valid = 1'b0;
    cyc();
    drive_ins(LD, 32'h44, 32'd0, 1'b1, 3'd0, 32'd0, 3'd2);
    cyc(); dc_valid = 1'b0;
    rob_clear = 1'b1;
    cyc(); rob_clear = 1'b0;
    tests++; if (mem_req !== 1'b1 || lsb_full !== 1'b1) begin fails++; $display("FAIL drain_state req=%0b full=%0b exp 1/1", mem_req, lsb_full); end
    drive_ins(LD, 32'h48, 32'd0, 1'b1, 3'd0, 32'd0, 3'd3);
    cyc(); dc_valid = 1'b0;
    mem_done = 1'b1; mem_rdata = 32'h5;
    cyc(); mem_done = 1'b0;
    tests++; if (lsb_has_output !== 1'b0 || mem_req !== 1'b0 || lsb_full !== 1'b0) begin
      fails++; $display("FAIL drain_done out=%0b req=%0b full=%0b exp 0/0/0", lsb_has_output, mem_req, lsb_full); end
    cyc(); cyc();
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL drain_no_reissue got=%0b exp=0", mem_req); end
  endtask

  task automatic test_flush_with_done;
    drive_ins(LD, 32'h60, 32'd0, 1'b1, 3'd0, 32'd0, 3'd4);
    cyc(); dc_valid = 1'b0;
    cyc();
    rob_clear = 1'b1; mem_done = 1'b1; mem_rdata = 32'h66;
    drive_ins(LD, 32'h64, 32'd0, 1'b1, 3'd0, 32'd0, 3'd5);
    cyc(); rob_clear = 1'b0; mem_done = 1'b0; dc_valid = 1'b0;
    tests++; if (lsb_has_output !== 1'b0 || mem_req !== 1'b0) begin fails++; $display("FAIL flushdone out=%0b req=%0b exp 0/0", lsb_has_output, mem_req); end
    cyc(); cyc();
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL flushdone_ins_ignored got=%0b exp=0", mem_req); end
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < DEPTH-1; i++) begin
      drive_ins(LD, 32'h2000, 32'(i*4), 1'b1, 3'd0, 32'd0, 3'(i));
      cyc();
    end
    dc_valid = 1'b0;
    tests++; if (lsb_full !== 1'b1 || mem_req !== 1'b1) begin fails++; $display("FAIL pre_reset full=%0b req=%0b exp 1/1", lsb_full, mem_req); end
    #2 rst_n_in = 1'b0;
    #1;
    tests++; if (mem_req !== 1'b0 || lsb_has_output !== 1'b0) begin fails++; $display("FAIL async_outputs req=%0b out=%0b exp 0/0", mem_req, lsb_has_output); end
    tests++; if (lsb_full !== 1'b0 || dut.count_q !== 4'd0) begin fails++; $display("FAIL async_count full=%0b count=%0d exp 0/0", lsb_full, dut.count_q); end
    cyc(); rst_n_in = 1'b1;
    cyc();
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL post_reset_idle got=%0b exp=0", mem_req); end
  endtask

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; rob_clear = 1'b0; rob_empty = 1'b1; rob_head_id = '0;
    dc_valid = 1'b0; dc_op = '0; dc_imm = '0; dc_iQi = 1'b1; dc_iQj = 1'b1;
    dc_Qi = '0; dc_Qj = '0; dc_Vi = '0; dc_Vj = '0; dc_Qdest = '0;
    cdb_valid = '0; cdb_rob_id = '0; cdb_data = '0;
    mem_stuck = 1'b0; mem_done = 1'b0; mem_rdata = '0;
    #1;
    test_reset();
    test_basic_load();
    test_cdb_wakeup();
    test_insert_bypass();
    test_mmio();
    test_rdy_stall();
    test_full_wrap();
    test_flush_busy();
    test_flush_with_done();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
